// File: rtl/stream_credit_gate.sv
// stream_credit_gate: AXI-Stream gate that caps the number of elements in flight
// (issued to the downstream pipeline but not yet retired) at a runtime limit.
// Beats enter a 2-entry skid buffer, and each beat takes a credit when it moves into
// the output register. The pipeline returns credits through a multi-bit release count.
module stream_credit_gate #(
   parameter int  MAX_NUMBER_OF_ELEMENTS = 128,
   parameter int  STREAM_WIDTH           = 32,
   parameter int  KEEP_WIDTH             = 1,
   parameter int  RELEASE_WIDTH          = 2,
   localparam int CNT_WIDTH              = $clog2(MAX_NUMBER_OF_ELEMENTS + 1)
) (
   input  logic                     aclk,
   input  logic                     resetn,
   input  logic                     s_axis_tvalid,
   output logic                     s_axis_tready,
   input  logic                     s_axis_tlast,
   input  logic [STREAM_WIDTH-1:0]  s_axis_tdata,
   input  logic [KEEP_WIDTH-1:0]    s_axis_tkeep,
   output logic                     m_axis_tvalid,
   input  logic                     m_axis_tready,
   output logic                     m_axis_tlast,
   output logic [STREAM_WIDTH-1:0]  m_axis_tdata,
   output logic [KEEP_WIDTH-1:0]    m_axis_tkeep,
   input  logic [RELEASE_WIDTH-1:0] sigRelease,
   input  logic [CNT_WIDTH-1:0]     limit,
   output logic [CNT_WIDTH-1:0]     inFlight,
   output logic                     full,
   output logic                     released,
   output logic                     errUnderflow
);

   // The credit sum is wide enough to hold inFlight + 1 and a full release count as a signed value
   localparam int SUM_W = ((CNT_WIDTH > RELEASE_WIDTH) ? CNT_WIDTH : RELEASE_WIDTH) + 2;
   localparam logic [CNT_WIDTH-1:0] MAX_CNT = CNT_WIDTH'(MAX_NUMBER_OF_ELEMENTS);

   // A limit of 0, or one above the hard ceiling, means "use the ceiling"
   function automatic logic [CNT_WIDTH-1:0] eff_limit_of(input logic [CNT_WIDTH-1:0] lim);
      if ((lim == '0) || (lim > MAX_CNT)) return MAX_CNT;
      return lim;
   endfunction

   // Saturate a signed credit sum at zero; a negative sum means over-release
   function automatic logic [CNT_WIDTH-1:0] clamp_credit(input logic signed [SUM_W-1:0] v);
      if (v[SUM_W-1]) return '0;
      return CNT_WIDTH'(v);
   endfunction

   logic [STREAM_WIDTH-1:0]  skid_data_p0 [2];
   logic [KEEP_WIDTH-1:0]    skid_keep_p0 [2];
   logic                     skid_last_p0 [2];
   logic                     wr_ptr_p0;
   logic                     rd_ptr_p0;
   logic [1:0]               skid_cnt_p0;
   logic [1:0]               skid_cnt_next;
   logic                     s_ready_p0;

   logic                     vld_p1;
   logic [STREAM_WIDTH-1:0]  data_p1;
   logic [KEEP_WIDTH-1:0]    keep_p1;
   logic                     last_p1;

   logic [CNT_WIDTH-1:0]     in_flight;
   logic [CNT_WIDTH-1:0]     eff_limit;
   logic signed [SUM_W-1:0]  credit_sum;
   logic                     err_q;
   logic                     push;
   logic                     load;

   assign push       = s_axis_tvalid & s_ready_p0;
   assign eff_limit  = eff_limit_of(limit);
   // Credit check uses the registered count only, so a released credit is usable next cycle
   assign load       = (~vld_p1 | m_axis_tready) & (skid_cnt_p0 != 2'd0) & (in_flight < eff_limit);
   assign credit_sum = $signed(SUM_W'(in_flight)) + $signed(SUM_W'(load))
                     - $signed(SUM_W'(sigRelease));

   // ---- stage p0: skid buffer ----

   // Skid occupancy after this cycle's push and pop
   always_comb begin
      skid_cnt_next = skid_cnt_p0;
      case ({push, load})
         2'b10:   skid_cnt_next = skid_cnt_p0 + 2'd1;
         2'b01:   skid_cnt_next = skid_cnt_p0 - 2'd1;
         default: skid_cnt_next = skid_cnt_p0;
      endcase
   end

   // Skid pointers, occupancy and the registered upstream ready
   always_ff @(posedge aclk or negedge resetn) begin
      if (!resetn) begin
         wr_ptr_p0   <= 1'b0;
         rd_ptr_p0   <= 1'b0;
         skid_cnt_p0 <= 2'd0;
         s_ready_p0  <= 1'b0;
      end else begin
         if (push) wr_ptr_p0 <= ~wr_ptr_p0;
         if (load) rd_ptr_p0 <= ~rd_ptr_p0;
         skid_cnt_p0 <= skid_cnt_next;
         s_ready_p0  <= (skid_cnt_next != 2'd2);
      end
   end

   // Skid storage; contents are only meaningful while counted as occupied
   always_ff @(posedge aclk) begin
      if (push) begin
         skid_data_p0[wr_ptr_p0] <= s_axis_tdata;
         skid_keep_p0[wr_ptr_p0] <= s_axis_tkeep;
         skid_last_p0[wr_ptr_p0] <= s_axis_tlast;
      end
   end

   // ---- stage p1: output register ----

   // Output beat: load from skid head, hold while stalled, empty after handshake
   always_ff @(posedge aclk or negedge resetn) begin
      if (!resetn) begin
         vld_p1  <= 1'b0;
         data_p1 <= '0;
         keep_p1 <= '0;
         last_p1 <= 1'b0;
      end else if (load) begin
         vld_p1  <= 1'b1;
         data_p1 <= skid_data_p0[rd_ptr_p0];
         keep_p1 <= skid_keep_p0[rd_ptr_p0];
         last_p1 <= skid_last_p0[rd_ptr_p0];
      end else if (m_axis_tready) begin
         vld_p1  <= 1'b0;
      end
   end

   // Credit counter and sticky underflow flag
   always_ff @(posedge aclk or negedge resetn) begin
      if (!resetn) begin
         in_flight <= '0;
         err_q     <= 1'b0;
      end else begin
         in_flight <= clamp_credit(credit_sum);
         if (credit_sum[SUM_W-1]) err_q <= 1'b1;
      end
   end

   assign s_axis_tready = s_ready_p0;
   assign m_axis_tvalid = vld_p1;
   assign m_axis_tdata  = data_p1;
   assign m_axis_tkeep  = keep_p1;
   assign m_axis_tlast  = last_p1;
   assign inFlight      = in_flight;
   assign full          = (in_flight >= eff_limit);
   assign released      = (in_flight == '0);
   assign errUnderflow  = err_q;

endmodule
